// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and constants for the two-port memory arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    localparam int STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/mem_arb_stat_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_stat_ctr
//  Purpose  : Saturating event counter for per-requester grant statistics.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_stat_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Bursting round-robin arbiter sharing one single-port synchronous
//             memory between two requesters. Define MEM_ARB_STATS_EN to add
//             saturating per-requester grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [N-1:0]      r0_addr_i,
    input  logic [N-1:0]      r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_rvalid_o,
    output logic [N-1:0]      r0_rdata_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [N-1:0]      r1_addr_i,
    input  logic [N-1:0]      r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_rvalid_o,
    output logic [N-1:0]      r1_rdata_o,
    output logic              mem_we_o,
    output logic [N-1:0]      mem_addr_o,
    output logic [N-1:0]      mem_write_o,
`ifdef MEM_ARB_STATS_EN
    output logic [STAT_W-1:0] stat_gnt0_o,
    output logic [STAT_W-1:0] stat_gnt1_o,
`endif
    input  logic [N-1:0]      mem_read_i
);

    localparam int             CW           = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0]  c_BURST_LAST = CW'(MAX_BURST - 1);

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic          w_gnt0, w_gnt1;
    logic          w_below_max;
    logic [CW-1:0] w_cnt_inc;

    assign w_below_max = (cnt_q < c_BURST_LAST);
    assign w_cnt_inc   = (cnt_q == c_BURST_LAST) ? cnt_q : cnt_q + 1'b1;

    // Owner keeps the memory until its burst budget runs out, but only while
    // the other side is actually waiting.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (owner_q)
            OWN0: begin
                if (r0_req_i && (!r1_req_i || w_below_max)) begin
                    w_gnt0 = 1'b1;
                end else if (r1_req_i) begin
                    w_gnt1 = 1'b1;
                end
            end
            OWN1: begin
                if (r1_req_i && (!r0_req_i || w_below_max)) begin
                    w_gnt1 = 1'b1;
                end else if (r0_req_i) begin
                    w_gnt0 = 1'b1;
                end
            end
            default: begin
                if (r0_req_i && r1_req_i) begin
                    w_gnt0 = last_q;
                    w_gnt1 = ~last_q;
                end else begin
                    w_gnt0 = r0_req_i;
                    w_gnt1 = r1_req_i;
                end
            end
        endcase
    end

    always_comb begin
        owner_d = IDLE;
        last_d  = last_q;
        cnt_d   = '0;
        if (w_gnt0) begin
            owner_d = OWN0;
            last_d  = 1'b0;
            cnt_d   = (owner_q == OWN0) ? w_cnt_inc : '0;
        end else if (w_gnt1) begin
            owner_d = OWN1;
            last_d  = 1'b1;
            cnt_d   = (owner_q == OWN1) ? w_cnt_inc : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= w_gnt0 & ~r0_we_i;
            rvalid1_q <= w_gnt1 & ~r1_we_i;
        end
    end

    assign r0_gnt_o    = w_gnt0;
    assign r1_gnt_o    = w_gnt1;
    assign r0_rvalid_o = rvalid0_q;
    assign r1_rvalid_o = rvalid1_q;
    assign r0_rdata_o  = mem_read_i;
    assign r1_rdata_o  = mem_read_i;

    assign mem_we_o    = (w_gnt0 & r0_we_i) | (w_gnt1 & r1_we_i);
    assign mem_addr_o  = w_gnt0 ? r0_addr_i  : (w_gnt1 ? r1_addr_i  : '0);
    assign mem_write_o = w_gnt0 ? r0_wdata_i : (w_gnt1 ? r1_wdata_i : '0);

`ifdef MEM_ARB_STATS_EN
    mem_arb_stat_ctr #(.W(STAT_W)) u_stat0 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_gnt0),
        .cnt_o (stat_gnt0_o)
    );

    mem_arb_stat_ctr #(.W(STAT_W)) u_stat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (w_gnt1),
        .cnt_o (stat_gnt1_o)
    );
`endif

endmodule
`default_nettype wire
